xmem_streamer: RTL and testbench
================================

XMEM_STREAMER -- requirements
Module: xmem_streamer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- bw, 4, activation bit width
- row, 8, lanes per word
- depth, 2048, memory words
- aw, 11, address width, equal to log2(depth)
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, asynchronous active-low reset
- wr_en, in, 1, host memory write strobe
- wr_addr, in, aw, host write address
- wr_data, in, bw*row, host write data
- start, in, 1, begin a stream
- start_addr, in, aw, first read address
- length, in, aw+1, word count
- dest, in, 1, destination: 0 = L0, 1 = IFIFO
- l0_full, in, 1, L0 backpressure
- ififo_full, in, 1, IFIFO backpressure
- out_data, out, bw*row, stream word
- l0_wr, out, 1, push to L0
- ififo_wr, out, 1, push to IFIFO
- busy, out, 1, stream active
- done, out, 1, one-cycle completion pulse

Function
REQ-004 The block SHALL hold an internal depth x (bw*row) memory with synchronous write and one-cycle synchronous read.
REQ-005 A write SHALL occur on every edge where wr_en=1, regardless of busy.
REQ-006 The FSM SHALL have states IDLE, RUN and FIN.
- IDLE to RUN on start=1 with length>0.
- IDLE to FIN on start=1 with length=0.
- RUN to FIN after the last push.
- FIN to IDLE unconditionally.
REQ-007 On start the block SHALL latch start_addr, length and dest; start SHALL be ignored outside IDLE.
REQ-008 busy SHALL be 1 in RUN and FIN; done SHALL be 1 only in FIN.
REQ-009 Reads SHALL issue at consecutive addresses from start_addr, wrapping modulo depth.
REQ-010 The block SHALL contain a 2-entry output buffer.
- A read SHALL issue only when (buffered + in-flight - popping) < 2 and words remain to be issued.
REQ-011 out_data SHALL present the buffer head.
- l0_wr = head_valid & ~dest & ~l0_full.
- ififo_wr = head_valid & dest & ~ififo_full.
- A push pops the head in the same cycle.
REQ-012 With no backpressure:
- The first push SHALL occur in the 2nd cycle after start is sampled.
- Pushes SHALL then continue one per cycle; length N completes in N+1 cycles after start, and done is asserted the cycle after the last push.
REQ-013 When the selected full input is high, no push SHALL occur, no word SHALL be lost or duplicated, and at most 2 words SHALL be buffered.
REQ-014 The full input of the unselected destination SHALL be ignored.
REQ-015 A same-cycle read and write to one address SHALL return the old data.
REQ-016 If out_data holds no valid word it SHALL be 0.

Reset
REQ-017 While reset=0 the block SHALL go to IDLE and clear buffer, counters, l0_wr, ififo_wr, busy, done and out_data to 0.
REQ-018 Reset SHALL NOT clear memory contents.
REQ-019 A reset mid-stream SHALL abort the stream with no further pushes and no done pulse.

Configuration
REQ-020 With STREAM_REPEAT_EN defined, the block SHALL add input rpt [3:0], latched on start.
- The block SHALL stream the same address range rpt+1 times back-to-back with no bubble between passes.
- done SHALL pulse once, after the final pass.
REQ-021 Without STREAM_REPEAT_EN, the rpt port SHALL be absent and each stream SHALL be a single pass.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Basic stream: write words 0..7 with data i*0x11111111, then start addr=0, len=8, dest=0 -> l0_wr high in cycles 2..9, data in order, done in cycle 10, ififo_wr never high.
- Wrap: start_addr=2046, len=4, dest=1 -> ififo words from addresses 2046, 2047, 0, 1.
- Backpressure: ififo_full high for 5 cycles mid-stream (len=6) -> all 6 words pushed exactly once in order, no push while full.
- Edge cases: len=0 -> done one cycle after start, no pushes; start while busy -> ignored.
- Reset abort: reset asserted at cycle 4 of a len=8 stream -> outputs 0 immediately, no done; a new stream then reads intact memory.
- Repeat (with STREAM_REPEAT_EN): rpt=2, len=3 -> 9 contiguous pushes with the sequence repeated, single done.

Source files
------------

// File: rtl/xmem_streamer_if.sv
// Host and stream-side bundle for xmem_streamer.
// rpt exists only when STREAM_REPEAT_EN is defined.
interface xmem_streamer_if #(
  parameter int bw  = 4,
  parameter int row = 8,
  parameter int aw  = 11
);
  logic              wr_en;
  logic [aw-1:0]     wr_addr;
  logic [bw*row-1:0] wr_data;
  logic              start;
  logic [aw-1:0]     start_addr;
  logic [aw:0]       length;
  logic              dest;
  logic              l0_full;
  logic              ififo_full;
  logic [bw*row-1:0] out_data;
  logic              l0_wr;
  logic              ififo_wr;
  logic              busy;
  logic              done;
`ifdef STREAM_REPEAT_EN
  logic [3:0]        rpt;
`endif

  modport master (
    output wr_en, wr_addr, wr_data,
    output start, start_addr, length, dest,
    output l0_full, ififo_full,
`ifdef STREAM_REPEAT_EN
    output rpt,
`endif
    input  out_data, l0_wr, ififo_wr,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  start, start_addr, length, dest,
    input  l0_full, ififo_full,
`ifdef STREAM_REPEAT_EN
    input  rpt,
`endif
    output out_data, l0_wr, ififo_wr,
    output busy, done
  );
endinterface

// File: rtl/xmem_streamer.sv
// Activation memory streamer into L0 or IFIFO with 2-entry output buffer.
// Optional STREAM_REPEAT_EN: replay the address range rpt+1 times.
module xmem_streamer #(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int depth = 2048,
  parameter int aw    = 11
) (
  input logic            clk,
  input logic            reset,
  xmem_streamer_if.slave io
);
  localparam int W = bw * row;
  localparam logic [aw:0] ONE = {{aw{1'b0}}, 1'b1};
  localparam logic [aw-1:0] LAST = aw'(depth - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state_q, state_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [aw-1:0] sa_q, sa_d;
  logic [aw:0] len_q, len_d;
  logic [aw:0] iss_q, iss_d;
  logic [aw:0] psh_q, psh_d;
  logic [3:0] ipass_q, ipass_d;
  logic [3:0] ppass_q, ppass_d;
  logic dest_q, dest_d;
  logic [W-1:0] b0_q, b0_d;
  logic [W-1:0] b1_q, b1_d;
  logic [1:0] cnt_q, cnt_d, c;
  logic rv_q, rv_d;

  logic [W-1:0] rdata_q;
  logic [W-1:0] mem [depth];

  logic [3:0] rpt_in;
  logic head_vld, sel_full, push;
  logic issue, take;
  logic [W-1:0] head;
  logic [2:0] occ;
  logic [aw-1:0] addr_inc;

`ifdef STREAM_REPEAT_EN
  assign rpt_in = io.rpt;
`else
  assign rpt_in = 4'd0;
`endif

  // No reset here so the array maps onto a RAM macro
  always_ff @(posedge clk) begin
    if (io.wr_en) mem[io.wr_addr] <= io.wr_data;
    if (issue) rdata_q <= mem[addr_q];
  end

  always_comb begin
    head_vld = (cnt_q != 2'd0) | rv_q;
    head     = '0;
    if (cnt_q != 2'd0) head = b0_q;
    else if (rv_q) head = rdata_q;
    sel_full = dest_q ? io.ififo_full : io.l0_full;
    push     = head_vld & ~sel_full;
    // words held after this cycle's pop, before a new read lands
    occ      = {1'b0, cnt_q} + {2'b0, rv_q} - {2'b0, push};
    issue    = (state_q == RUN) & (iss_q != '0)
             & (occ < 3'd2);
    addr_inc = (addr_q == LAST) ? '0 : addr_q + 1'b1;
  end

  always_comb begin
    b0_d = b0_q;
    b1_d = b1_q;
    c    = cnt_q;
    take = rv_q & ~(push & (cnt_q == 2'd0));
    if (push && cnt_q != 2'd0) begin
      b0_d = b1_q;
      c    = cnt_q - 2'd1;
    end
    if (take) begin
      if (c == 2'd0) b0_d = rdata_q;
      else b1_d = rdata_q;
      c = c + 2'd1;
    end
    cnt_d = c;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sa_d    = sa_q;
    len_d   = len_q;
    iss_d   = iss_q;
    psh_d   = psh_q;
    ipass_d = ipass_q;
    ppass_d = ppass_q;
    dest_d  = dest_q;
    rv_d    = issue;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          sa_d    = io.start_addr;
          addr_d  = io.start_addr;
          len_d   = io.length;
          iss_d   = io.length;
          psh_d   = io.length;
          dest_d  = io.dest;
          ipass_d = rpt_in;
          ppass_d = rpt_in;
          state_d = (io.length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (iss_q == ONE && ipass_q != 4'd0) begin
            iss_d   = len_q;
            addr_d  = sa_q;
            ipass_d = ipass_q - 4'd1;
          end else begin
            iss_d  = iss_q - ONE;
            addr_d = addr_inc;
          end
        end
        if (push) begin
          if (psh_q == ONE) begin
            if (ppass_q == 4'd0) begin
              state_d = FIN;
            end else begin
              psh_d   = len_q;
              ppass_d = ppass_q - 4'd1;
            end
          end else begin
            psh_d = psh_q - ONE;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sa_q    <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      psh_q   <= '0;
      ipass_q <= '0;
      ppass_q <= '0;
      dest_q  <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sa_q    <= sa_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      psh_q   <= psh_d;
      ipass_q <= ipass_d;
      ppass_q <= ppass_d;
      dest_q  <= dest_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
    end
  end

  assign io.out_data = head;
  assign io.l0_wr    = push & ~dest_q;
  assign io.ififo_wr = push & dest_q;
  assign io.busy     = (state_q != IDLE);
  assign io.done     = (state_q == FIN);
endmodule

// File: tb/tb_xmem_streamer.sv
// Scoreboard bench for xmem_streamer.
// Cycle k is observed 1ns after the negedge following posedge k.
module tb_xmem_streamer;
  localparam int BW = 4;
  localparam int ROW = 8;
  localparam int DEPTH = 2048;
  localparam int AW = 11;
  localparam int W = BW * ROW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  xmem_streamer_if #(.bw(BW), .row(ROW), .aw(AW)) bus ();

  xmem_streamer #(
    .bw(BW), .row(ROW), .depth(DEPTH), .aw(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus.slave)
  );

  logic [W-1:0] model [DEPTH];
  logic [W-1:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic idle_inputs();
    bus.wr_en = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start = 0;
    bus.start_addr = '0;
    bus.length = '0;
    bus.dest = 0;
    bus.l0_full = 0;
    bus.ififo_full = 0;
`ifdef STREAM_REPEAT_EN
    bus.rpt = 4'd0;
`endif
  endtask

  task automatic mem_wr(input logic [AW-1:0] a,
                        input logic [W-1:0] d);
    @(negedge clk);
    bus.wr_en = 1;
    bus.wr_addr = a;
    bus.wr_data = d;
    model[a] = d;
    @(negedge clk);
    bus.wr_en = 0;
  endtask

  task automatic go(input logic [AW-1:0] sa,
                    input logic [AW:0] len,
                    input logic d);
    @(negedge clk);
    bus.start = 1;
    bus.start_addr = sa;
    bus.length = len;
    bus.dest = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    n_chk++;
    if (bus.l0_wr !== 1'b0 || bus.ififo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wr got=%b%b exp=00",
               bus.l0_wr, bus.ififo_wr);
    end
    n_chk++;
    if (bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0", bus.out_data);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 8; i++) mem_wr(AW'(i), W'(i) * 32'h11111111);
    mem_wr(11'd2046, 32'hA5A5_0001);
    mem_wr(11'd2047, 32'hA5A5_0002);
    for (int i = 20; i < 23; i++) mem_wr(AW'(i), $urandom);
    for (int i = 100; i < 106; i++) mem_wr(AW'(i), $urandom);
    for (int i = 200; i < 204; i++) mem_wr(AW'(i), $urandom);
  endtask

  task automatic test_basic();
    logic [W-1:0] e;
    logic ew;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i) * 32'h11111111);
    go(11'd0, 12'd8, 1'b0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      bus.ififo_full = (cyc % 2 == 1);
      #1;
      ew = (cyc >= 2 && cyc <= 9);
      n_chk++;
      if (bus.l0_wr !== ew) begin
        n_fail++;
        $display("FAIL basic_l0_wr cyc=%0d got=%b exp=%b",
                 cyc, bus.l0_wr, ew);
      end
      if (bus.l0_wr === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL basic_data cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      n_chk++;
      if (bus.done !== (cyc == 10)) begin
        n_fail++;
        $display("FAIL basic_done cyc=%0d got=%b", cyc, bus.done);
      end
      n_chk++;
      if (bus.ififo_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_ififo cyc=%0d got=%b exp=0",
                 cyc, bus.ififo_wr);
      end
    end
    bus.ififo_full = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    logic ew;
    exp_q.delete();
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0002);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h1111_1111);
    go(11'd2046, 12'd4, 1'b1);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      bus.l0_full = 1;
      #1;
      ew = (cyc >= 2 && cyc <= 5);
      n_chk++;
      if (bus.ififo_wr !== ew || bus.l0_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_wr cyc=%0d got=%b%b exp=0%b",
                 cyc, bus.l0_wr, bus.ififo_wr, ew);
      end
      if (bus.ififo_wr === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL wrap_data cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      n_chk++;
      if (bus.done !== (cyc == 6)) begin
        n_fail++;
        $display("FAIL wrap_done cyc=%0d got=%b", cyc, bus.done);
      end
    end
    bus.l0_full = 0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int pushes = 0;
    exp_q.delete();
    for (int i = 100; i < 106; i++) exp_q.push_back(model[i]);
    go(11'd100, 12'd6, 1'b1);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      bus.ififo_full = (cyc >= 3 && cyc <= 7);
      #1;
      n_chk++;
      if (bus.ififo_full && bus.ififo_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_push_full cyc=%0d got=%b exp=0",
                 cyc, bus.ififo_wr);
      end
      if (bus.ififo_wr === 1'b1) begin
        pushes++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra cyc=%0d got=%h exp=none",
                   cyc, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_fail++;
            $display("FAIL bp_data cyc=%0d got=%h exp=%h",
                     cyc, bus.out_data, e);
          end
        end
      end
      n_chk++;
      if (bus.done !== (cyc == 13)) begin
        n_fail++;
        $display("FAIL bp_done cyc=%0d got=%b", cyc, bus.done);
      end
    end
    bus.ififo_full = 0;
    n_chk++;
    if (pushes != 6) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=6", pushes);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] e;
    logic ew;
    go(11'd5, 12'd0, 1'b0);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      #1;
      n_chk++;
      if (bus.done !== (cyc == 1) || bus.busy !== (cyc == 1)) begin
        n_fail++;
        $display("FAIL len0_done cyc=%0d got=%b%b",
                 cyc, bus.done, bus.busy);
      end
      n_chk++;
      if (bus.l0_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL len0_push cyc=%0d got=%b exp=0",
                 cyc, bus.l0_wr);
      end
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(model[i]);
    go(11'd0, 12'd3, 1'b0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      bus.start = (cyc <= 2 || cyc == 5);
      bus.start_addr = 11'd50;
      bus.length = 12'd5;
      bus.dest = 1;
      #1;
      ew = (cyc >= 2 && cyc <= 4);
      n_chk++;
      if (bus.l0_wr !== ew || bus.ififo_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_start_wr cyc=%0d got=%b%b exp=%b0",
                 cyc, bus.l0_wr, bus.ififo_wr, ew);
      end
      if (bus.l0_wr === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL busy_start_data cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      n_chk++;
      if (bus.done !== (cyc == 5) || bus.busy !== (cyc <= 5)) begin
        n_fail++;
        $display("FAIL busy_start_ctl cyc=%0d got=%b%b",
                 cyc, bus.done, bus.busy);
      end
    end
    bus.start = 0;
    bus.dest = 0;
  endtask

  task automatic test_rw_collision();
    logic [W-1:0] e;
    int pushes = 0;
    exp_q.delete();
    for (int i = 200; i < 203; i++) exp_q.push_back(model[i]);
    exp_q.push_back(32'hBEEF_0203);
    go(11'd200, 12'd4, 1'b0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      bus.wr_en = (cyc <= 2);
      bus.wr_addr = (cyc == 1) ? 11'd200 : 11'd203;
      bus.wr_data = (cyc == 1) ? 32'hBEEF_0200 : 32'hBEEF_0203;
      if (cyc <= 2) model[bus.wr_addr] = bus.wr_data;
      #1;
      if (bus.l0_wr === 1'b1 && exp_q.size() > 0) begin
        pushes++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL rw_data cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      n_chk++;
      if (bus.done !== (cyc == 6)) begin
        n_fail++;
        $display("FAIL rw_done cyc=%0d got=%b", cyc, bus.done);
      end
    end
    bus.wr_en = 0;
    n_chk++;
    if (pushes != 4) begin
      n_fail++;
      $display("FAIL rw_count got=%0d exp=4", pushes);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] e;
    logic ew;
    int pushes = 0;
    go(11'd0, 12'd8, 1'b0);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      #1;
      n_chk++;
      if (bus.l0_wr !== (cyc >= 2)) begin
        n_fail++;
        $display("FAIL abort_pre cyc=%0d got=%b", cyc, bus.l0_wr);
      end
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_chk++;
    if (bus.out_data !== '0 || bus.l0_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_out got=%h/%b exp=0/0",
               bus.out_data, bus.l0_wr);
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ctl got=%b%b exp=00", bus.busy, bus.done);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (bus.l0_wr !== 1'b0 || bus.done !== 1'b0 ||
          bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cyc=%0d got=%b%b%b exp=000",
                 cyc, bus.l0_wr, bus.done, bus.busy);
      end
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i) * 32'h11111111);
    go(11'd0, 12'd8, 1'b0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      #1;
      ew = (cyc >= 2 && cyc <= 9);
      if (bus.l0_wr === 1'b1 && exp_q.size() > 0) begin
        pushes++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL abort_mem cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      n_chk++;
      if (bus.l0_wr !== ew || bus.done !== (cyc == 10)) begin
        n_fail++;
        $display("FAIL abort_rerun cyc=%0d got=%b%b",
                 cyc, bus.l0_wr, bus.done);
      end
    end
    n_chk++;
    if (pushes != 8) begin
      n_fail++;
      $display("FAIL abort_count got=%0d exp=8", pushes);
    end
  endtask

`ifdef STREAM_REPEAT_EN
  task automatic test_repeat();
    logic [W-1:0] e;
    logic ew;
    int dones = 0;
    exp_q.delete();
    for (int p = 0; p < 3; p++)
      for (int i = 20; i < 23; i++) exp_q.push_back(model[i]);
    bus.rpt = 4'd2;
    go(11'd20, 12'd3, 1'b0);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      bus.start = 0;
      bus.rpt = 4'd0;
      #1;
      ew = (cyc >= 2 && cyc <= 10);
      n_chk++;
      if (bus.l0_wr !== ew) begin
        n_fail++;
        $display("FAIL rpt_wr cyc=%0d got=%b exp=%b",
                 cyc, bus.l0_wr, ew);
      end
      if (bus.l0_wr === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.out_data !== e) begin
          n_fail++;
          $display("FAIL rpt_data cyc=%0d got=%h exp=%h",
                   cyc, bus.out_data, e);
        end
      end
      if (bus.done === 1'b1) dones++;
      n_chk++;
      if (bus.done !== (cyc == 11)) begin
        n_fail++;
        $display("FAIL rpt_done cyc=%0d got=%b", cyc, bus.done);
      end
    end
    n_chk++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL rpt_dones got=%0d exp=1", dones);
    end
  endtask
`endif

  initial begin
    test_reset();
    load_mem();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edges();
    test_rw_collision();
    test_reset_abort();
`ifdef STREAM_REPEAT_EN
    test_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
